// File: rtl/ysyx_25040105_ifu_if.sv
// Bundle of the IFU's bus-side signals: instruction-memory request/response,
// the execute-stage redirect, and the fetched-instruction handshake toward decode.
// master = the IFU itself, slave = everything around it (memory, execute, decode).
interface ysyx_25040105_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch stage. Holds the PC, keeps at most one instruction-memory
// read in flight, and hands each fetched word plus its PC to decode over a
// valid/ready handshake. Execute redirects reload the PC at any time; a read
// already in flight at that moment is flagged and its data thrown away.
module ysyx_25040105_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_25040105_ifu_if.master       bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a read request
    S_WAIT = 2'd1,  // request accepted, waiting for the response
    S_HOLD = 2'd2   // instruction offered to decode
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        drop_q, drop_d;
  // Low during reset and for the first cycle after release, so no request is
  // ever presented while rst_n is asserted.
  logic        running_q, running_d;

  logic        req_valid;
  logic        req_fire;
  logic        rsp_keep;

  // Request handshake and whether an arriving response is worth keeping.
  always_comb begin
    req_valid = (state_q == S_REQ) && running_q;
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_keep  = !drop_q && !bus.redirect_valid;
    running_d = 1'b1;
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  // Next-state logic: REQ -> WAIT -> HOLD -> REQ, short-circuited by redirects.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (bus.imem_rsp_valid) state_d = (drop_q || bus.redirect_valid) ? S_REQ : S_HOLD;
      S_HOLD:  if (bus.redirect_valid || bus.inst_ready) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // Datapath next values: PC advance, response capture, stale-read tracking.
  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;
    case (state_q)
      S_REQ: begin
        // A redirect in the same cycle the request is accepted makes that read stale.
        if (req_fire) drop_d = bus.redirect_valid;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          drop_d = 1'b0;
          if (rsp_keep) begin
            inst_d       = bus.imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;  // wraps naturally at 2^32
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect squashes the held instruction even if decode takes it.
        if (bus.redirect_valid || bus.inst_ready) inst_valid_d = 1'b0;
      end
      default: ;
    endcase
    // A redirect always wins over the sequential PC.
    if (bus.redirect_valid) pc_d = {bus.redirect_pc[31:2], 2'b00};
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      drop_q       <= drop_d;
      running_q    <= running_d;
    end
  end

  // Outputs: all come straight from registers or the state.
  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = pc_q;
    bus.inst_valid     = inst_valid_q;
    bus.inst           = inst_q;
    bus.inst_pc        = inst_pc_q;
  end

endmodule
